// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM stage of the 5-stage pipeline. Runs loads and stores over a
// request/acknowledge data-memory bus. The upstream pipeline stalls while an
// access is outstanding, and the MEM/WB register is loaded once per
// instruction. A watchdog abandons any access that is not acknowledged within
// ACK_TIMEOUT WAIT cycles and raises a sticky error.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   RegWrite_in .. MemWrite_in EX/MEM control bits
//   ALU_result_in              address for memory ops, result otherwise
//   reg_read_data_2_in         store data
//   EX_MEM_RegisterRd_in       destination register
//   dmem_req/we/addr/wdata     registered data-memory request
//   dmem_ack, dmem_rdata       one-cycle completion pulse and load data
//   MEM_Stall                  combinational freeze of PC .. EX/MEM
//   RegWrite_out .. MEM_WB_RegisterRd_out  MEM/WB register
//   mem_err                    sticky watchdog error
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops pass straight to MEM/WB
// WAIT  | request on the bus, waiting for dmem_ack or the watchdog
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_Stall,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  MEM_WB_RegisterRd_out,
  output logic        mem_err
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_mtr_q, wb_mtr_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        err_q, err_d;
  logic        stall;

  logic mem_op;
  logic last_cnt;
  assign mem_op   = MemRead_in | MemWrite_in;
  assign last_cnt = (cnt_q == CNT_LAST);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mem_op) state_d = S_WAIT;
      S_WAIT: if (dmem_ack || last_cnt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs and datapath next values; MEM/WB defaults to a bubble
  always_comb begin
    stall      = 1'b0;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    wb_rw_d    = 1'b0;
    wb_mtr_d   = 1'b0;
    wb_rdata_d = '0;
    wb_alu_d   = '0;
    wb_rd_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWrite_in;
          addr_d  = ALU_result_in;
          wdata_d = reg_read_data_2_in;
          cnt_d   = '0;
        end else begin
          wb_rw_d  = RegWrite_in;
          wb_mtr_d = MemtoReg_in;
          wb_alu_d = ALU_result_in;
          wb_rd_d  = EX_MEM_RegisterRd_in;
        end
      end
      S_WAIT: begin
        // The EX/MEM inputs are still frozen by the stall, so the completing
        // instruction is captured straight from them. An ack beats the
        // watchdog when both land in the same cycle.
        if (dmem_ack || last_cnt) begin
          req_d    = 1'b0;
          wb_rw_d  = RegWrite_in;
          wb_mtr_d = MemtoReg_in;
          wb_alu_d = ALU_result_in;
          wb_rd_d  = EX_MEM_RegisterRd_in;
          if (dmem_ack) begin
            if (!MemWrite_in) wb_rdata_d = dmem_rdata;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_mtr_q   <= 1'b0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      wb_rw_q    <= wb_rw_d;
      wb_mtr_q   <= wb_mtr_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  // Held low through reset so a pending memory op in EX/MEM cannot freeze
  // the pipeline while the stage is being cleared.
  assign MEM_Stall             = stall & ~reset;
  assign dmem_req              = req_q;
  assign dmem_we               = we_q;
  assign dmem_addr             = addr_q;
  assign dmem_wdata            = wdata_q;
  assign RegWrite_out          = wb_rw_q;
  assign MemtoReg_out          = wb_mtr_q;
  assign mem_read_data_out     = wb_rdata_q;
  assign ALU_result_out        = wb_alu_q;
  assign MEM_WB_RegisterRd_out = wb_rd_q;
  assign mem_err               = err_q;

endmodule
